cl_fill_unit: RTL
=================

// Module: cl_fill_unit
// PURPOSE
//  Write-side partner of the cache data store. Collects a cache-line fill from memory in MEM_W beats,
//  reads the target set (all 4 ways) from the store, and merges the new line into the selected way.
//  It then writes the set back through the store's writeback/alloc port.
//  Sits between the miss handler (request side), the memory response bus, and the data store.
// PARAMETERS
//  CL_SIZE  512  bits per way line; store set width = CL_SIZE*4
//  IDX_CNT  8    store index width (matches store idx/idx_in_wb ports)
//  MEM_W    128  memory beat width; BEATS = CL_SIZE/MEM_W (integer, >=2)
//  TMO_CYC  64   beat-gap watchdog limit (used only with CL_FILL_TIMEOUT_EN)
// PORTS
//  clk           in   1           clock, all state on posedge
//  rst           in   1           asynchronous, active-low reset
//  req_valid     in   1           fill request
//  req_ready     out  1           high only in IDLE
//  req_idx       in   IDX_CNT     target set index
//  req_way       in   2           target way 0..3
//  mem_valid     in   1           memory beat valid
//  mem_ready     out  1           high only in FILL
//  mem_data      in   MEM_W       beat payload, beat 0 = line bits [MEM_W-1:0]
//  ds_operation  out  3           store read op; 3'b001 in RD, else 3'b000
//  ds_idx        out  IDX_CNT     store read index (idx_q)
//  ds_cl_lines   in   CL_SIZE*4   store read data, valid the cycle after ds_operation!=0
//  ds_cl_in_wb   out  CL_SIZE*4   merged set to write
//  ds_idx_in_wb  out  IDX_CNT     write index (idx_q)
//  ds_alloc      out  1           store write strobe, one cycle in WR
//  ds_st_fwd     out  1           tied 0
//  fill_done     out  1           one-cycle pulse, coincident with ds_alloc
//  fill_err      out  1           one-cycle abort pulse (CL_FILL_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst==0, async): state=IDLE, beat_cnt=0, line/merged/idx_q/way_q regs=0, all outputs 0
//    except req_ready=1 after release. Reset mid-fill discards the partial line; no alloc is issued.
//  - FSM is Moore; outputs decode registered state/regs only.
//  - IDLE: req_valid&&req_ready latches idx_q/way_q, beat_cnt=0 -> FILL.
//  - FILL: each mem_valid&&mem_ready writes mem_data to line[beat_cnt*MEM_W +: MEM_W] and increments
//    beat_cnt. Gaps (mem_valid=0) just hold. Accepting beat BEATS-1 -> RD; beat_cnt returns to 0.
//  - RD (1 cycle): ds_operation=3'b001, ds_idx=idx_q -> WAIT.
//  - WAIT (1 cycle): merged = ds_cl_lines with [way_q*CL_SIZE +: CL_SIZE] replaced by line.
//    The other 3 ways are copied unchanged -> WR.
//  - WR (1 cycle): ds_alloc=1, fill_done=1, ds_idx_in_wb=idx_q, ds_cl_in_wb=merged -> IDLE.
//  - Latency: last beat accepted at cycle N; RD at N+1, WAIT at N+2, alloc/done at N+3.
//    The next request is accepted at N+4 at the earliest.
//  - ds_cl_in_wb/ds_idx_in_wb hold their last value outside WR; the store only samples them when ds_alloc=1.
//  - req_valid is ignored outside IDLE. mem_valid is ignored outside FILL; no beat is consumed there.
//  - BEATS counter width = clog2(BEATS); no wrap beyond BEATS-1.
// CONFIGURATION
//  CL_FILL_TIMEOUT_EN defined:
//   - gap counter resets on each accepted beat and on entry to FILL; it increments on FILL cycles
//     without a beat.
//   - Reaching TMO_CYC: fill_err pulses 1 cycle, state -> IDLE, no ds_operation/ds_alloc.
//   - Partial line dropped.
//  CL_FILL_TIMEOUT_EN undefined:
//   - no counter; FILL waits indefinitely; fill_err tied 0.
// TESTING
//  1 req idx=5 way=0, beats 0x1..,0x2..,0x3..,0x4.. back-to-back:
//    RD at N+1 with idx 5; alloc at N+3 with way0=concat(beats), ways1-3 = prior store contents; done=1.
//  2 store set 2 preloaded ways {A,B,C,D}, fill way 3 with line E:
//    ds_cl_in_wb = {E,C,B,A} (way3 high), idx_in_wb=2.
//  3 mem_valid gaps of 0,3,1,5 cycles between beats:
//    identical merged data to scenario 1; mem_ready high throughout FILL only.
//  4 rst low after beat 2 of 4: outputs 0 immediately (async); after release req_ready=1.
//    No alloc seen; a new fill then completes correctly.
//  5 second req_valid held during fill, released after done: accepted exactly one cycle after WR.
//    Stray mem_valid during RD/WAIT/WR is not consumed.
//  6 (CL_FILL_TIMEOUT_EN, TMO_CYC=8) one beat then silence:
//    fill_err pulse on the 8th idle cycle, no ds_alloc, req_ready=1 next cycle.

Source files
------------

// File: rtl/cl_fill_unit.sv
// cl_fill_unit: collects a cache-line fill from memory in MEM_W-wide beats,
// reads the target set from the data store, merges the new line into the
// selected way and writes the whole set back through the alloc port.
// Optional feature macro: CL_FILL_TIMEOUT_EN (beat-gap watchdog, TMO_CYC cycles).
module cl_fill_unit #(
    parameter int CL_SIZE = 512,
    parameter int IDX_CNT = 8,
    parameter int MEM_W   = 128,
    parameter int TMO_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDX_CNT-1:0]     req_idx,
    input  logic [1:0]             req_way,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [MEM_W-1:0]       mem_data,
    output logic [2:0]             ds_operation,
    output logic [IDX_CNT-1:0]     ds_idx,
    input  logic [CL_SIZE*4-1:0]   ds_cl_lines,
    output logic [CL_SIZE*4-1:0]   ds_cl_in_wb,
    output logic [IDX_CNT-1:0]     ds_idx_in_wb,
    output logic                   ds_alloc,
    output logic                   ds_st_fwd,
    output logic                   fill_done,
    output logic                   fill_err
);

    localparam int BEATS = CL_SIZE / MEM_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_WR   = 3'd4
    } state_t;

    // Reject geometries the beat counter and merge cannot represent.
    if ((CL_SIZE % MEM_W) != 0 || (CL_SIZE / MEM_W) < 2 || TMO_CYC < 2) begin : g_bad_cfg
        $error("cl_fill_unit: unsupported CL_SIZE/MEM_W/TMO_CYC combination");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_live;
    logic [BCW-1:0]       r_beat_cnt;
    logic [CL_SIZE-1:0]   r_line;
    logic [CL_SIZE*4-1:0] r_merged;
    logic [IDX_CNT-1:0]   r_idx;
    logic [1:0]           r_way;
    logic                 w_req_ready;
    logic                 w_mem_ready;
    logic                 w_req_take;
    logic                 w_beat;
    logic                 w_tmo;

`ifdef CL_FILL_TIMEOUT_EN
    localparam int GCW = $clog2(TMO_CYC + 1);
    logic [GCW-1:0] r_gap;

    // Gap watchdog: counts FILL cycles without a beat, cleared by beats and outside FILL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap <= '0;
        end else if (r_state != S_FILL || w_beat) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + 1'b1;
        end
    end

    // The last silent cycle before the limit aborts the fill; no beat is taken in it.
    assign w_tmo = (r_state == S_FILL) && (r_gap == GCW'(TMO_CYC - 1));
`else
    assign w_tmo = 1'b0;
`endif

    assign w_req_ready = (r_state == S_IDLE) && r_live;
    assign w_mem_ready = (r_state == S_FILL) && !w_tmo;
    assign w_req_take  = req_valid && w_req_ready;
    assign w_beat      = mem_valid && w_mem_ready;

    // State register; r_live keeps req_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path through the case leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_req_take) w_state_nxt = S_FILL;
            S_FILL: begin
                if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                end else if (w_beat && r_beat_cnt == LAST_BEAT) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD:   w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_WR;
            S_WR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch request, assemble beats into the line, merge line into the read set.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: line and merged-set registers are reset so a fill aborted by reset leaves nothing behind.
        if (!rst) begin
            r_beat_cnt <= '0;
            r_line     <= '0;
            r_merged   <= '0;
            r_idx      <= '0;
            r_way      <= '0;
        end else begin
            if (w_req_take) begin
                r_idx      <= req_idx;
                r_way      <= req_way;
                r_beat_cnt <= '0;
            end
            if (w_beat) begin
                r_line[r_beat_cnt*MEM_W +: MEM_W] <= mem_data;
                r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                for (int w = 0; w < 4; w++) begin
                    r_merged[w*CL_SIZE +: CL_SIZE] <= (r_way == 2'(w)) ? r_line
                                                    : ds_cl_lines[w*CL_SIZE +: CL_SIZE];
                end
            end
        end
    end

    // Moore outputs: decoded from registered state and registers only.
    assign req_ready    = w_req_ready;
    assign mem_ready    = w_mem_ready;
    assign ds_operation = (r_state == S_RD) ? 3'b001 : 3'b000;
    assign ds_idx       = r_idx;
    assign ds_cl_in_wb  = r_merged;
    assign ds_idx_in_wb = r_idx;
    assign ds_alloc     = (r_state == S_WR);
    assign fill_done    = (r_state == S_WR);
    assign ds_st_fwd    = 1'b0;
    assign fill_err     = w_tmo;

endmodule
